// File: rtl/rca_op_sequencer.sv
// -----------------------------------------------------------------------------
// rca_op_sequencer
//   Sequential wrapper around a purely combinational ripple-carry adder.
//   It accepts an operand transaction on a valid/ready input and drives the
//   adder inputs from registers. After a programmable settle time it samples
//   the adder outputs and compares them with an internally computed golden
//   sum. The result is presented on a valid/ready output, and the block keeps
//   saturating counters of completed results and of failing results.
//
// Parameters
//   N       adder operand width (must match the adder)
//   SETTLE  cycles from operand drive to sampling, legal range 1..15
//   CW      width of txn_cnt / err_cnt
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand handshake
//   in_a, in_b, in_cin         operands
//   rca_a, rca_b, rca_cin      registered operands driven to the adder
//   rca_sum, rca_cout          adder outputs
//   out_valid/out_ready        result handshake
//   out_res                    sampled {rca_cout, rca_sum}
//   out_err                    sampled result differs from golden (with out_valid)
//   txn_cnt, err_cnt           saturating handshake / error counters
//   clr_cnt                    synchronous clear of both counters
// -----------------------------------------------------------------------------
module rca_op_sequencer #(
  parameter int N      = 4,
  parameter int SETTLE = 2,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic          in_cin,
  output logic [N-1:0]  rca_a,
  output logic [N-1:0]  rca_b,
  output logic          rca_cin,
  input  logic [N-1:0]  rca_sum,
  input  logic          rca_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N:0]    out_res,
  output logic          out_err,
  output logic [CW-1:0] txn_cnt,
  output logic [CW-1:0] err_cnt,
  input  logic          clr_cnt
);

  localparam int RW   = N + 1;
  localparam int CNTW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t          state;
  logic [CNTW-1:0] settle_cnt;
  logic [RW-1:0]   golden;
  logic [RW-1:0]   sample;
  logic            out_hs;

  assign sample = {rca_cout, rca_sum};
  assign out_hs = out_valid && out_ready;

  // NOTE: all state here is sequential, so every assignment uses <=; mixing in
  // blocking assignments would make results depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      golden     <= '0;
      in_ready   <= 1'b1;
      rca_a      <= '0;
      rca_b      <= '0;
      rca_cin    <= 1'b0;
      out_valid  <= 1'b0;
      out_res    <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            rca_a      <= in_a;
            rca_b      <= in_b;
            rca_cin    <= in_cin;
            // Zero-extend before adding so the carry out lands in bit N.
            golden     <= RW'(in_a) + RW'(in_b) + RW'(in_cin);
            settle_cnt <= CNTW'(SETTLE - 1);
            in_ready   <= 1'b0;
            state      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            out_res   <= sample;
            out_err   <= (sample != golden);
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        ST_HOLD: begin
          // in_ready rises together with the handshake, so the next operand
          // can only be taken on the following edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Saturating counters; a clear in the same cycle as a handshake wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
      err_cnt <= '0;
    end else if (clr_cnt) begin
      txn_cnt <= '0;
      err_cnt <= '0;
    end else if (out_hs) begin
      if (txn_cnt != '1) txn_cnt <= txn_cnt + 1'b1;
      if (out_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rca_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rca_op_sequencer
//   Directed bench for rca_op_sequencer (N=4, SETTLE=2). A behavioural adder
//   stub with an optional bit0-stuck-at-0 fault sits around the DUT. Expected
//   results are pushed into a scoreboard queue by the stimulus process and
//   popped by a monitor whenever an output handshake is presented.
// -----------------------------------------------------------------------------
module tb_rca_op_sequencer;

  localparam int N      = 4;
  localparam int SETTLE = 2;
  localparam int CW     = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic          in_cin;
  logic [N-1:0]  rca_a;
  logic [N-1:0]  rca_b;
  logic          rca_cin;
  logic [N-1:0]  rca_sum;
  logic          rca_cout;
  logic          out_valid;
  logic          out_ready;
  logic [N:0]    out_res;
  logic          out_err;
  logic [CW-1:0] txn_cnt;
  logic [CW-1:0] err_cnt;
  logic          clr_cnt;

  logic          fault;
  logic [N:0]    full_sum;

  int checks = 0;
  int errors = 0;

  // {exp_err, exp_res}
  logic [N+1:0] sb_q[$];

  rca_op_sequencer #(.N(N), .SETTLE(SETTLE), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .rca_a    (rca_a),
    .rca_b    (rca_b),
    .rca_cin  (rca_cin),
    .rca_sum  (rca_sum),
    .rca_cout (rca_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_err  (out_err),
    .txn_cnt  (txn_cnt),
    .err_cnt  (err_cnt),
    .clr_cnt  (clr_cnt)
  );

  // Adder stub, optionally with SUM bit0 stuck at 0.
  assign full_sum = {1'b0, rca_a} + {1'b0, rca_b} + {{N{1'b0}}, rca_cin};
  assign rca_sum  = fault ? {full_sum[N-1:1], 1'b0} : full_sum[N-1:0];
  assign rca_cout = full_sum[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented output handshake against the scoreboard.
  initial begin
    logic [N+1:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got res %0h err %0b with empty scoreboard",
                   out_res, out_err);
        end else begin
          exp = sb_q.pop_front();
          check("out_res", 32'(out_res), 32'(exp[N:0]));
          check("out_err", 32'(out_err), 32'(exp[N+1]));
        end
      end
    end
  end

  // Present one operand; returns just after the accepting edge.
  task automatic drive_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges from the accept edge to out_valid, accept edge excluded.
  task automatic check_latency();
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(SETTLE));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                         input logic [N:0] res, input logic err, input bit wait_done);
    sb_q.push_back({err, res});
    drive_op(a, b, c);
    check_latency();
    if (wait_done) wait_idle();
  endtask

  initial begin
    bit seen_valid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    fault     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state after 5 idle cycles.
    repeat (5) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rca_a",     32'(rca_a),     32'd0);
    check("rst_rca_b",     32'(rca_b),     32'd0);
    check("rst_rca_cin",   32'(rca_cin),   32'd0);
    check("rst_out_res",   32'(out_res),   32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_txn_cnt",   32'(txn_cnt),   32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);

    // Basic transaction: 3+5+1 = 9.
    run_txn(4'h3, 4'h5, 1'b1, 5'h09, 1'b0, 1'b1);
    check("txn_cnt_1",  32'(txn_cnt), 32'd1);
    check("rca_a_hold", 32'(rca_a),   32'h3);
    check("rca_b_hold", 32'(rca_b),   32'h5);

    // Maximum operands carry out, then all-zero.
    run_txn(4'hF, 4'hF, 1'b1, 5'h1F, 1'b0, 1'b1);
    run_txn(4'h0, 4'h0, 1'b0, 5'h00, 1'b0, 1'b1);
    check("txn_cnt_3", 32'(txn_cnt), 32'd3);
    check("err_cnt_0", 32'(err_cnt), 32'd0);

    // Faulty adder: 1+0+0 reads back as 0, golden is 1.
    fault = 1'b1;
    run_txn(4'h1, 4'h0, 1'b0, 5'h00, 1'b1, 1'b1);
    fault = 1'b0;
    check("err_cnt_1", 32'(err_cnt), 32'd1);
    check("txn_cnt_4", 32'(txn_cnt), 32'd4);

    // Backpressure: result held 10 cycles, new operands ignored.
    out_ready = 1'b0;
    run_txn(4'h6, 4'h7, 1'b0, 5'h0D, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_a     = 4'h9;
    in_b     = 4'h2;
    in_cin   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_res",   32'(out_res),   32'h0D);
      check("stall_in_ready",  32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    check("stall_rca_a", 32'(rca_a), 32'h6);
    out_ready = 1'b1;
    wait_idle();
    check("txn_cnt_5", 32'(txn_cnt), 32'd5);

    // Clear coincident with a handshake: clear wins.
    out_ready = 1'b0;
    run_txn(4'h2, 4'h2, 1'b0, 5'h04, 1'b0, 1'b0);
    clr_cnt   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("clr_txn_cnt",   32'(txn_cnt),   32'd0);
    check("clr_err_cnt",   32'(err_cnt),   32'd0);
    check("clr_out_valid", 32'(out_valid), 32'd0);

    // Carry into bit N without carry-in: 8+8 = 0x10.
    run_txn(4'h8, 4'h8, 1'b0, 5'h10, 1'b0, 1'b1);
    check("txn_cnt_after_clr", 32'(txn_cnt), 32'd1);

    // Reset during SETTLE: result discarded, counters zeroed.
    drive_op(4'h1, 4'h1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_txn_cnt",   32'(txn_cnt),   32'd0);
    check("midrst_rca_a",     32'(rca_a),     32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("midrst_no_valid",  32'(seen_valid), 32'd0);
    check("midrst_ready_rel", 32'(in_ready),   32'd1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
